// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the address-width function, default-sized typedefs and REG_ZERO.
package regfile_pkg;

  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = calc_aw(NUM_REGS_DEF);

  typedef logic [AW_DEF-1:0]     reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus its popcount.
// Ports: wr_en_i/wr_addr_i (writeback clears), iss_en_i/iss_addr_i (issue
// sets), flush_i (clears all), busy_o (bits), hit_o (write-hit mask),
// busy_cnt_o (registered popcount).
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int WR_PORTS = 2,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WR_PORTS-1:0]          wr_en_i,
  input  logic [WR_PORTS-1:0][AW-1:0]  wr_addr_i,
  input  logic [WR_PORTS-1:0]          iss_en_i,
  input  logic [WR_PORTS-1:0][AW-1:0]  iss_addr_i,
  input  logic                         flush_i,
  output logic [NUM_REGS-1:0]          busy_o,
  output logic [NUM_REGS-1:0]          hit_o,
  output logic [AW:0]                  busy_cnt_o
);

  logic [NUM_REGS-1:0] r_busy;
  logic [AW:0]         r_cnt;
  logic [NUM_REGS-1:0] w_hit;
  logic [NUM_REGS-1:0] w_iss;
  logic [NUM_REGS-1:0] w_busy_d;
  logic [AW:0]         w_cnt_d;

  always_comb begin
    w_hit = '0;
    w_iss = '0;
    for (int k = 0; k < WR_PORTS; k++) begin
      if (wr_en_i[k])  w_hit[wr_addr_i[k]]  = 1'b1;
      if (iss_en_i[k]) w_iss[iss_addr_i[k]] = 1'b1;
    end
    w_hit[0] = 1'b0;
    // Issue after clear: a new producer outranks the retiring one.
    w_busy_d = (r_busy & ~w_hit) | w_iss;
    if (flush_i) w_busy_d = '0;
    w_busy_d[0] = 1'b0;
    w_cnt_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_cnt_d = w_cnt_d + {{AW{1'b0}}, w_busy_d[r]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_d;
      r_cnt  <= w_cnt_d;
    end
  end

  assign busy_o     = r_busy;
  assign hit_o      = w_hit;
  assign busy_cnt_o = r_cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass.
// Ports: rd_addr_i/rd_data_o/rd_busy_o (comb reads), wr_* (sync writes),
// iss_* (scoreboard set), flush_i (scoreboard clear), busy_cnt_o.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  parameter bit BYPASS   = 1'b1,
  parameter int AW       = calc_aw(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [RD_PORTS-1:0][AW-1:0]     rd_addr_i,
  output logic [RD_PORTS-1:0][DATA_W-1:0] rd_data_o,
  output logic [RD_PORTS-1:0]             rd_busy_o,
  input  logic [WR_PORTS-1:0]             wr_en_i,
  input  logic [WR_PORTS-1:0][AW-1:0]     wr_addr_i,
  input  logic [WR_PORTS-1:0][DATA_W-1:0] wr_data_i,
  input  logic [WR_PORTS-1:0]             iss_en_i,
  input  logic [WR_PORTS-1:0][AW-1:0]     iss_addr_i,
  input  logic                            flush_i,
  output logic [AW:0]                     busy_cnt_o
);

  localparam logic [AW-1:0] A0 = AW'(REG_ZERO);

  logic [DATA_W-1:0]   r_mem [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_hit;

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .WR_PORTS (WR_PORTS),
    .AW       (AW)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en_i),
    .wr_addr_i  (wr_addr_i),
    .iss_en_i   (iss_en_i),
    .iss_addr_i (iss_addr_i),
    .flush_i    (flush_i),
    .busy_o     (w_busy),
    .hit_o      (w_hit),
    .busy_cnt_o (busy_cnt_o)
  );

  // Later ports are applied last, so the higher index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_mem[r] <= '0;
    end else begin
      for (int k = 0; k < WR_PORTS; k++) begin
        if (wr_en_i[k] && wr_addr_i[k] != A0) begin
          r_mem[wr_addr_i[k]] <= wr_data_i[k];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rd_data_o[p] = r_mem[rd_addr_i[p]];
      rd_busy_o[p] = w_busy[rd_addr_i[p]];
      if (BYPASS) begin
        if (w_hit[rd_addr_i[p]]) rd_busy_o[p] = 1'b0;
        for (int k = 0; k < WR_PORTS; k++) begin
          if (wr_en_i[k] && wr_addr_i[k] == rd_addr_i[p]) begin
            rd_data_o[p] = wr_data_i[k];
          end
        end
      end
      if (rd_addr_i[p] == A0) begin
        rd_data_o[p] = '0;
        rd_busy_o[p] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed and model-checked bench for regfile_mp.
// Two instances share stimulus: u_a with BYPASS=1, u_b with BYPASS=0.
module tb_regfile_mp;

  localparam int RP = 4;
  localparam int WP = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [RP-1:0][AW-1:0] rd_addr;
  logic [RP-1:0][DW-1:0] rd_data_a, rd_data_b;
  logic [RP-1:0]         rd_busy_a, rd_busy_b;
  logic [WP-1:0]         wr_en;
  logic [WP-1:0][AW-1:0] wr_addr;
  logic [WP-1:0][DW-1:0] wr_data;
  logic [WP-1:0]         iss_en;
  logic [WP-1:0][AW-1:0] iss_addr;
  logic                  flush;
  logic [AW:0]           cnt_a, cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(32), .RD_PORTS(RP),
               .WR_PORTS(WP), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
    .rd_busy_o(rd_busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .flush_i(flush), .busy_cnt_o(cnt_a));

  regfile_mp #(.DATA_W(DW), .NUM_REGS(32), .RD_PORTS(RP),
               .WR_PORTS(WP), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
    .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .iss_en_i(iss_en), .iss_addr_i(iss_addr),
    .flush_i(flush), .busy_cnt_o(cnt_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0;
    iss_en = '0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    iss_addr = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int a = 0; a < 32; a++) begin
      rd_addr[0] = AW'(a);
      #1;
      n_cmp++;
      if (rd_data_a[0] !== 0 || rd_busy_a[0] !== 0 ||
          rd_data_b[0] !== 0 || rd_busy_b[0] !== 0) begin
        n_err++;
        $display("FAIL reset_read x%0d: got %h/%b %h/%b need 0/0",
                 a, rd_data_a[0], rd_busy_a[0], rd_data_b[0], rd_busy_b[0]);
      end
    end
    n_cmp++;
    if (cnt_a !== 0 || cnt_b !== 0) begin
      n_err++;
      $display("FAIL reset_cnt: got %0d/%0d need 0", cnt_a, cnt_b);
    end
    wr_en[0] = 1'b1; wr_addr[0] = 5; wr_data[0] = 32'hDEADBEEF;
    tick();
    idle();
    rd_addr[0] = 5;
    #1;
    n_cmp++;
    if (rd_data_b[0] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL x5_before_rst: got %h need deadbeef", rd_data_b[0]);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (rd_data_a[0] !== 0 || rd_data_b[0] !== 0) begin
      n_err++;
      $display("FAIL mid_rst_x5: got %h/%h need 0", rd_data_a[0], rd_data_b[0]);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    wr_en[0] = 1'b1; wr_addr[0] = 7; wr_data[0] = 32'h1234;
    rd_addr[0] = 7;
    #1;
    n_cmp++;
    if (rd_data_a[0] !== 32'h1234 || rd_data_b[0] !== 0) begin
      n_err++;
      $display("FAIL bypass_same: got %h/%h need 1234/0",
               rd_data_a[0], rd_data_b[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data_a[0] !== 32'h1234 || rd_data_b[0] !== 32'h1234) begin
      n_err++;
      $display("FAIL bypass_next: got %h/%h need 1234",
               rd_data_a[0], rd_data_b[0]);
    end
  endtask

  task automatic test_wr_conflict();
    wr_en = 2'b11;
    wr_addr[0] = 3; wr_data[0] = 32'hAAAA;
    wr_addr[1] = 3; wr_data[1] = 32'h5555;
    rd_addr[1] = 3;
    #1;
    n_cmp++;
    if (rd_data_a[1] !== 32'h5555) begin
      n_err++;
      $display("FAIL conflict_bypass: got %h need 5555", rd_data_a[1]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data_a[1] !== 32'h5555 || rd_data_b[1] !== 32'h5555) begin
      n_err++;
      $display("FAIL conflict_store: got %h/%h need 5555",
               rd_data_a[1], rd_data_b[1]);
    end
    wr_en[0] = 1'b1; wr_addr[0] = 0; wr_data[0] = 32'hFFFF;
    rd_addr[2] = 0;
    #1;
    n_cmp++;
    if (rd_data_a[2] !== 0 || rd_busy_a[2] !== 0) begin
      n_err++;
      $display("FAIL x0_same: got %h/%b need 0/0", rd_data_a[2], rd_busy_a[2]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_data_a[2] !== 0 || rd_data_b[2] !== 0 || rd_busy_b[2] !== 0) begin
      n_err++;
      $display("FAIL x0_after: got %h/%h busy %b need 0",
               rd_data_a[2], rd_data_b[2], rd_busy_b[2]);
    end
  endtask

  task automatic test_scoreboard();
    iss_en[0] = 1'b1; iss_addr[0] = 9;
    rd_addr[0] = 9;
    #1;
    n_cmp++;
    if (rd_busy_a[0] !== 0) begin
      n_err++;
      $display("FAIL iss_same_cycle: got %b need 0", rd_busy_a[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy_a[0] !== 1 || rd_busy_b[0] !== 1 || cnt_a !== 1) begin
      n_err++;
      $display("FAIL iss_next: got %b/%b cnt %0d need 1/1 cnt 1",
               rd_busy_a[0], rd_busy_b[0], cnt_a);
    end
    wr_en[1] = 1'b1; wr_addr[1] = 9; wr_data[1] = 32'h99;
    #1;
    n_cmp++;
    if (rd_busy_a[0] !== 0 || rd_busy_b[0] !== 1) begin
      n_err++;
      $display("FAIL wb_same: got %b/%b need 0/1", rd_busy_a[0], rd_busy_b[0]);
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy_a[0] !== 0 || rd_busy_b[0] !== 0 || cnt_a !== 0 ||
        rd_data_b[0] !== 32'h99) begin
      n_err++;
      $display("FAIL wb_next: got %b/%b cnt %0d data %h need 0/0 cnt 0 99",
               rd_busy_a[0], rd_busy_b[0], cnt_a, rd_data_b[0]);
    end
    iss_en[0] = 1'b1; iss_addr[0] = 9;
    wr_en[1] = 1'b1; wr_addr[1] = 9; wr_data[1] = 32'h42;
    tick();
    idle();
    #1;
    n_cmp++;
    if (rd_busy_a[0] !== 1 || cnt_b !== 1 || rd_data_a[0] !== 32'h42) begin
      n_err++;
      $display("FAIL iss_wins: got %b cnt %0d data %h need 1 cnt 1 42",
               rd_busy_a[0], cnt_b, rd_data_a[0]);
    end
    wr_en[0] = 1'b1; wr_addr[0] = 9; wr_data[0] = 32'h42;
    tick();
    idle();
  endtask

  task automatic test_flush();
    iss_en = 2'b11; iss_addr[0] = 1; iss_addr[1] = 2;
    tick();
    iss_addr[0] = 3; iss_addr[1] = 4;
    tick();
    idle();
    #1;
    n_cmp++;
    if (cnt_a !== 4 || cnt_b !== 4) begin
      n_err++;
      $display("FAIL cnt_four: got %0d/%0d need 4", cnt_a, cnt_b);
    end
    flush = 1'b1;
    iss_en[0] = 1'b1; iss_addr[0] = 6;
    wr_en[0] = 1'b1; wr_addr[0] = 2; wr_data[0] = 32'h77;
    tick();
    idle();
    rd_addr[0] = 1; rd_addr[1] = 2; rd_addr[2] = 6; rd_addr[3] = 4;
    #1;
    n_cmp++;
    if (rd_busy_a !== 0 || rd_busy_b !== 0 || cnt_a !== 0 || cnt_b !== 0) begin
      n_err++;
      $display("FAIL flush_busy: got %b/%b cnt %0d/%0d need 0",
               rd_busy_a, rd_busy_b, cnt_a, cnt_b);
    end
    n_cmp++;
    if (rd_data_a[1] !== 32'h77 || rd_data_b[1] !== 32'h77) begin
      n_err++;
      $display("FAIL flush_data: got %h/%h need 77", rd_data_a[1], rd_data_b[1]);
    end
  endtask

  task automatic test_stress();
    logic [DW-1:0] m_mem [32];
    logic          m_busy [32];
    logic [DW-1:0] ed;
    logic          eb, hit;
    int            ec, a;
    // Start from a known state.
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin
      m_mem[r] = '0;
      m_busy[r] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < RP; p++) rd_addr[p] = AW'($urandom_range(0, 7));
      for (int k = 0; k < WP; k++) begin
        wr_en[k] = ($urandom_range(0, 2) == 0);
        wr_addr[k] = AW'($urandom_range(0, 7));
        wr_data[k] = $urandom;
        iss_en[k] = ($urandom_range(0, 2) == 0);
        iss_addr[k] = AW'($urandom_range(0, 7));
      end
      flush = ($urandom_range(0, 15) == 0);
      #1;
      for (int p = 0; p < RP; p++) begin
        a = int'(rd_addr[p]);
        ed = m_mem[a];
        hit = 1'b0;
        for (int k = 0; k < WP; k++) begin
          if (wr_en[k] && int'(wr_addr[k]) == a) begin
            ed = wr_data[k];
            hit = 1'b1;
          end
        end
        eb = m_busy[a] && !hit;
        if (a == 0) begin
          ed = '0;
          eb = 1'b0;
        end
        n_cmp++;
        if (rd_data_a[p] !== ed || rd_busy_a[p] !== eb) begin
          n_err++;
          $display("FAIL stress_byp c%0d p%0d x%0d: got %h/%b need %h/%b",
                   c, p, a, rd_data_a[p], rd_busy_a[p], ed, eb);
        end
        n_cmp++;
        if (rd_data_b[p] !== m_mem[a] || rd_busy_b[p] !== m_busy[a]) begin
          n_err++;
          $display("FAIL stress_nobyp c%0d p%0d x%0d: got %h/%b need %h/%b",
                   c, p, a, rd_data_b[p], rd_busy_b[p], m_mem[a], m_busy[a]);
        end
      end
      ec = 0;
      for (int r = 0; r < 32; r++) ec += int'(m_busy[r]);
      n_cmp++;
      if (int'(cnt_a) != ec || int'(cnt_b) != ec) begin
        n_err++;
        $display("FAIL stress_cnt c%0d: got %0d/%0d need %0d",
                 c, cnt_a, cnt_b, ec);
      end
      for (int k = 0; k < WP; k++) begin
        if (wr_en[k] && wr_addr[k] != 0) begin
          m_mem[int'(wr_addr[k])] = wr_data[k];
          m_busy[int'(wr_addr[k])] = 1'b0;
        end
      end
      for (int k = 0; k < WP; k++) begin
        if (iss_en[k] && iss_addr[k] != 0) m_busy[int'(iss_addr[k])] = 1'b1;
      end
      if (flush) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_wr_conflict();
    test_scoreboard();
    test_flush();
    test_stress();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a pending-write scoreboard, for the decode stage of the dual-issue pipeline. It provides RD_PORTS combinational read ports and WR_PORTS synchronous write ports, with optional write-to-read bypass. Per-register busy bits let decode detect RAW hazards against writes still in flight: issue sets a bit, writeback clears it, flush clears all of them. Register 0 is hardwired to zero and is never busy.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count (power of two, ≥2); AW = $clog2(NUM_REGS)
- RD_PORTS, 2, read port count (1..4)
- WR_PORTS, 2, write port count (1..2)
- BYPASS, 1, 1 = a same-cycle write is visible on reads; 0 = reads return stored value
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr_i  in  RD_PORTS×AW  read addresses
- rd_data_o  out  RD_PORTS×DATA_W  read data
- rd_busy_o  out  RD_PORTS  addressed register has a write pending
- wr_en_i  in  WR_PORTS  write enables (writeback)
- wr_addr_i  in  WR_PORTS×AW  write addresses
- wr_data_i  in  WR_PORTS×DATA_W  write data
- iss_en_i  in  WR_PORTS  issue valid: destination will be written later
- iss_addr_i  in  WR_PORTS×AW  issued destination addresses
- flush_i  in  1  clear all busy bits (pipeline flush)
- busy_cnt_o  out  AW+1  number of set busy bits

## Operation
- Reset: all registers = 0, all busy bits = 0. Outputs are then rd_data_o = 0, rd_busy_o = 0, busy_cnt_o = 0. Reset may assert mid-operation; it overrides every write, issue and flush.
- Read, per port: address 0 → data 0, busy 0. Otherwise, if BYPASS and any wr_en_i[k] matches the address, data = wr_data_i of the highest-index matching port. Otherwise data = stored value.
- Write: on the edge, every enabled port with a nonzero address updates its register. If two ports target the same address, the higher index wins. Writes to address 0 are dropped.
- Scoreboard next state, per register r≠0, applied in order:
  1. Cleared if any enabled write hits r.
  2. Set if any iss_en_i hits r. Issue wins over a same-cycle write: the new producer is still pending.
  3. flush_i forces all bits to 0, overriding issue and write.
- Busy bit 0 is constant 0.
- rd_busy_o = busy_q[addr], masked to 0 when BYPASS and a same-cycle write hits addr. A same-cycle issue to addr does not raise rd_busy_o until the next cycle.
- busy_cnt_o is the registered popcount of the busy bits. It is updated on the same edge as the bits, so it is never stale relative to busy_q.
- A write to a non-busy register is legal. It updates data and leaves busy at 0.

## Timing
- Read data and busy are combinational from addresses and same-cycle write inputs: zero-cycle latency.
- A write is visible through storage on the cycle after the edge, and in the same cycle when BYPASS=1.
- Issue → rd_busy_o high: 1 cycle. Writeback → rd_busy_o low: 0 cycles with BYPASS, 1 cycle without.
- flush_i → all busy 0 and busy_cnt_o 0 on the next cycle. Data writes in the flush cycle still commit.
- No handshake and no stall: every input is sampled every cycle.

## Structure
- Shared package regfile_pkg holds:
  - the AW computation function;
  - the reg_addr_t / reg_data_t typedefs, sized from the defaults;
  - the constant REG_ZERO = 0.
- Sub-module regfile_scoreboard holds busy_q, the set/clear/flush priority logic and the popcount register. It exports busy_q and the write-hit mask.
- The top level holds storage, the write-port priority logic and the read/bypass muxes.

## Test plan
- Reset, then read all addresses: data 0, busy 0, busy_cnt_o 0. Write x5 = 0xDEADBEEF, then assert rst mid-cycle: x5 reads 0 immediately.
- BYPASS=1: wr x7 = 0x1234 and read x7 in the same cycle → 0x1234. Repeat with BYPASS=0 → old value, then 0x1234 next cycle.
- Both write ports target x3 (0xAAAA on port 0, 0x5555 on port 1) → x3 = 0x5555. Write x0 = 0xFFFF → x0 still reads 0, busy 0.
- Issue x9 → rd_busy_o high next cycle, busy_cnt_o = 1. Writeback x9 → same-cycle busy 0 (BYPASS=1) and count 0 next cycle. Issue and write x9 in the same cycle → busy stays 1.
- Issue x1..x4 over two cycles → busy_cnt_o = 4. flush_i together with an issue of x6 and a write of x2 = 0x77 → next cycle all busy 0, count 0, x2 = 0x77.
- Random stress with 4 read and 2 write ports against a reference model: data and busy match every cycle.
